// File: rtl/text_console_ctrl_if.sv
// rtl/text_console_ctrl_if.sv - CPU byte stream, character RAM write port and display status bundle
interface text_console_ctrl_if;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [11:0] base_addr;
    logic [7:0]  base_addr_y;
    logic [7:0]  cur_col;
    logic [7:0]  cur_row;
    logic        busy;

    modport master (
        output ch_valid, ch_data,
        input  ch_ready, ram_we, ram_addr, ram_wdata,
        input  base_addr, base_addr_y, cur_col, cur_row, busy
    );

    modport slave (
        input  ch_valid, ch_data,
        output ch_ready, ram_we, ram_addr, ram_wdata,
        output base_addr, base_addr_y, cur_col, cur_row, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - character RAM sequencer: control-code decode, cursor tracking, circular scroll and clears
module text_console_ctrl #(
    parameter int         COLS           = 70,
    parameter int         ROWS           = 30,
    parameter logic [7:0] SPACE          = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                pclk,
    input  logic                reset,
    text_console_ctrl_if.slave  bus
);
    localparam logic [11:0] TOTAL    = 12'(COLS * ROWS);
    localparam logic [11:0] COLS_W   = 12'(COLS);
    localparam logic [11:0] LAST_LB  = 12'(COLS * ROWS - COLS);
    localparam logic [7:0]  COL_LAST = 8'(COLS - 1);
    localparam logic [7:0]  ROW_LAST = 8'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR_ALL : IDLE;

    state_t      state, state_d;
    logic [7:0]  col_q, col_d, row_q, row_d, bay_q, bay_d, wdata_q, wdata_d;
    logic [11:0] lb_q, lb_d, ba_q, ba_d, addr_q, addr_d, cnt_q, cnt_d;
    logic        we_q, we_d, adv_q, adv_d, do_nl;
    logic [11:0] phys, lb_plus, ba_plus;
    logic [7:0]  bay_plus;

    // Physical rows are multiples of COLS, so a wrap check on equality is enough
    assign phys     = lb_q + {4'b0, col_q};
    assign lb_plus  = (lb_q == LAST_LB) ? 12'd0 : lb_q + COLS_W;
    assign ba_plus  = (ba_q == LAST_LB) ? 12'd0 : ba_q + COLS_W;
    assign bay_plus = (bay_q == ROW_LAST) ? 8'd0 : bay_q + 8'd1;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state   <= RESET_STATE;
            col_q   <= '0;
            row_q   <= '0;
            bay_q   <= '0;
            ba_q    <= '0;
            lb_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            adv_q   <= 1'b0;
        end else begin
            state   <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bay_q   <= bay_d;
            ba_q    <= ba_d;
            lb_q    <= lb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            adv_q   <= adv_d;
        end
    end

    always_comb begin
        state_d = state;
        col_d   = col_q;
        row_d   = row_q;
        bay_d   = bay_q;
        ba_d    = ba_q;
        lb_d    = lb_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        adv_d   = adv_q;
        do_nl   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ch_valid) begin
                    if (bus.ch_data >= 8'h20 && bus.ch_data <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = phys;
                        wdata_d = bus.ch_data;
                        adv_d   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        unique case (bus.ch_data)
                            8'h0A: do_nl = 1'b1;
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != 8'd0) begin
                                    col_d   = col_q - 8'd1;
                                    we_d    = 1'b1;
                                    addr_d  = phys - 12'd1;
                                    wdata_d = SPACE;
                                    adv_d   = 1'b0;
                                    state_d = WRITE;
                                end
                            end
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                bay_d   = '0;
                                ba_d    = '0;
                                lb_d    = '0;
                                we_d    = 1'b1;
                                addr_d  = '0;
                                wdata_d = SPACE;
                                cnt_d   = 12'd1;
                                state_d = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (adv_q) begin
                    if (col_q < COL_LAST) col_d = col_q + 8'd1;
                    else                  do_nl = 1'b1;
                end
            end
            CLEAR_LINE: begin
                if (cnt_q == COLS_W) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = lb_q + cnt_q;
                    wdata_d = SPACE;
                    cnt_d   = cnt_q + 12'd1;
                end
            end
            CLEAR_ALL: begin
                if (cnt_q == TOTAL) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = SPACE;
                    cnt_d   = cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // On scroll the old top line becomes the bottom line; its first blank is issued here
        if (do_nl) begin
            col_d = '0;
            if (row_q != ROW_LAST) begin
                row_d   = row_q + 8'd1;
                lb_d    = lb_plus;
                state_d = IDLE;
            end else begin
                bay_d   = bay_plus;
                ba_d    = ba_plus;
                lb_d    = ba_q;
                we_d    = 1'b1;
                addr_d  = ba_q;
                wdata_d = SPACE;
                cnt_d   = 12'd1;
                state_d = CLEAR_LINE;
            end
        end
    end

    assign bus.ch_ready    = (state == IDLE);
    assign bus.busy        = (state == CLEAR_LINE) || (state == CLEAR_ALL);
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.base_addr   = ba_q;
    assign bus.base_addr_y = bay_q;
    assign bus.cur_col     = col_q;
    assign bus.cur_row     = row_q;
endmodule
